// File: rtl/dec_entry_ctrl_pkg.sv
// Shared types and key-code constants for the decimal keypad entry controller.
package dec_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [4:0]  KEY_BKSP   = 5'h10;
    localparam logic [4:0]  KEY_CLR    = 5'h11;
    localparam logic [4:0]  KEY_ENT    = 5'h12;
    localparam int unsigned MAX_DIGITS = 3;

endpackage

// File: rtl/dec_entry_ctrl_if.sv
// Keypad strobe input and valid/ready result port of the decimal entry controller.
interface dec_entry_ctrl_if #(
    parameter int unsigned KEY_W = 5
);
    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic             val_valid;
    logic             val_ready;
    logic [9:0]       val_data;

    modport master (
        output key_valid, key_code, val_ready,
        input  val_valid, val_data
    );

    modport slave (
        input  key_valid, key_code, val_ready,
        output val_valid, val_data
    );
endinterface

// File: rtl/dec_entry_ctrl_bcd3_to_bin.sv
// Combinational three-digit BCD to binary conversion: h*100 + t*10 + o.
module bcd3_to_bin (
    input  logic [3:0] i_hund,
    input  logic [3:0] i_ten,
    input  logic [3:0] i_one,
    output logic [9:0] o_bin
);
    // 100 = 64+32+4, 10 = 8+2
    always_comb begin
        o_bin = {i_hund, 6'b0}
              + {1'b0, i_hund, 5'b0}
              + {4'b0, i_hund, 2'b0}
              + {3'b0, i_ten, 3'b0}
              + {5'b0, i_ten, 1'b0}
              + {6'b0, i_one};
    end
endmodule

// File: rtl/dec_entry_ctrl.sv
// Decimal keypad entry sequencer: up to three BCD digits, converted to binary on enter.
// Optional idle auto-clear in ENTRY is enabled by defining DEC_ENTRY_TIMEOUT_EN.
module dec_entry_ctrl
    import dec_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned KEY_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    dec_entry_ctrl_if.slave bus,
    output logic [3:0] d_hund,
    output logic [3:0] d_ten,
    output logic [3:0] d_one,
    output logic [1:0] digit_cnt,
    output logic       err
`ifdef DEC_ENTRY_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);
    state_t     r_state, w_nxt_state;
    logic [3:0] r_hund, r_ten, r_one;
    logic [3:0] w_nxt_hund, w_nxt_ten, w_nxt_one;
    logic [1:0] r_cnt, w_nxt_cnt;
    logic [9:0] r_val_data, w_nxt_data, w_bin;
    logic       r_err, w_nxt_err;
    logic       w_clear, w_is_digit;
`ifdef DEC_ENTRY_TIMEOUT_EN
    logic [31:0] r_idle_cnt, w_nxt_idle;
    logic        r_timeout, w_nxt_timeout;
`endif

    bcd3_to_bin u_conv (
        .i_hund (r_hund),
        .i_ten  (r_ten),
        .i_one  (r_one),
        .o_bin  (w_bin)
    );

    assign w_is_digit = (bus.key_code < KEY_W'(10));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_hund  = r_hund;
        w_nxt_ten   = r_ten;
        w_nxt_one   = r_one;
        w_nxt_cnt   = r_cnt;
        w_nxt_data  = r_val_data;
        w_nxt_err   = 1'b0;
        w_clear     = 1'b0;
`ifdef DEC_ENTRY_TIMEOUT_EN
        w_nxt_timeout = 1'b0;
        w_nxt_idle    = '0;
        if (!bus.key_valid && r_state == ENTRY && r_idle_cnt != TIMEOUT_CYCLES - 1)
            w_nxt_idle = r_idle_cnt + 32'd1;
`endif
        case (r_state)
            HOLD: begin
                // A handshake coinciding with a non-clear key still completes; the key is rejected.
                if (bus.key_valid && bus.key_code == KEY_W'(KEY_CLR)) begin
                    w_clear = 1'b1;
                end else begin
                    w_nxt_err = bus.key_valid;
                    if (bus.val_ready)
                        w_clear = 1'b1;
                end
            end
            default: begin
                if (bus.key_valid) begin
                    if (w_is_digit) begin
                        if (r_cnt < 2'(MAX_DIGITS)) begin
                            w_nxt_hund  = r_ten;
                            w_nxt_ten   = r_one;
                            w_nxt_one   = bus.key_code[3:0];
                            w_nxt_cnt   = r_cnt + 2'd1;
                            w_nxt_state = ENTRY;
                        end else begin
                            w_nxt_err = 1'b1;
                        end
                    end else if (bus.key_code == KEY_W'(KEY_BKSP)) begin
                        if (r_cnt != 2'd0) begin
                            w_nxt_one   = r_ten;
                            w_nxt_ten   = r_hund;
                            w_nxt_hund  = '0;
                            w_nxt_cnt   = r_cnt - 2'd1;
                            w_nxt_state = (r_cnt == 2'd1) ? IDLE : ENTRY;
                        end
                    end else if (bus.key_code == KEY_W'(KEY_CLR)) begin
                        w_clear = 1'b1;
                    end else if (bus.key_code == KEY_W'(KEY_ENT)) begin
                        if (r_cnt == 2'd0) begin
                            w_nxt_err = 1'b1;
                        end else begin
                            w_nxt_data  = w_bin;
                            w_nxt_state = HOLD;
                        end
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end
`ifdef DEC_ENTRY_TIMEOUT_EN
                else if (r_state == ENTRY && r_idle_cnt == TIMEOUT_CYCLES - 1) begin
                    w_clear       = 1'b1;
                    w_nxt_timeout = 1'b1;
                end
`endif
            end
        endcase
        if (w_clear) begin
            w_nxt_hund  = '0;
            w_nxt_ten   = '0;
            w_nxt_one   = '0;
            w_nxt_cnt   = '0;
            w_nxt_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hund     <= '0;
            r_ten      <= '0;
            r_one      <= '0;
            r_cnt      <= '0;
            r_val_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_hund     <= w_nxt_hund;
            r_ten      <= w_nxt_ten;
            r_one      <= w_nxt_one;
            r_cnt      <= w_nxt_cnt;
            r_val_data <= w_nxt_data;
            r_err      <= w_nxt_err;
        end
    end

`ifdef DEC_ENTRY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_idle_cnt <= w_nxt_idle;
            r_timeout  <= w_nxt_timeout;
        end
    end

    assign timeout = r_timeout;
`endif

    assign bus.val_valid = (r_state == HOLD);
    assign bus.val_data  = r_val_data;
    assign d_hund        = r_hund;
    assign d_ten         = r_ten;
    assign d_one         = r_one;
    assign digit_cnt     = r_cnt;
    assign err           = r_err;
endmodule

// File: tb/tb_dec_entry_ctrl.sv
// Self-checking bench for dec_entry_ctrl: directed vector table, HOLD/reset sequences, random run vs model.
module tb_dec_entry_ctrl;
    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d_hund, d_ten, d_one;
    logic [1:0] digit_cnt;
    logic       err;
`ifdef DEC_ENTRY_TIMEOUT_EN
    logic       timeout;
`endif

    dec_entry_ctrl_if #(.KEY_W(5)) bus ();

    dec_entry_ctrl #(.TIMEOUT_CYCLES(TO), .KEY_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .d_hund    (d_hund),
        .d_ten     (d_ten),
        .d_one     (d_one),
        .digit_cnt (digit_cnt),
        .err       (err)
`ifdef DEC_ENTRY_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge: drive for one cycle, return at the following negedge.
    task automatic cyc(input bit kv, input int kc, input bit rdy);
        bus.key_valid = kv;
        bus.key_code  = 5'(kc);
        bus.val_ready = rdy;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.val_ready = 1'b0;
    endtask

    // Behavioural model: digit string held as a queue, value computed as a decimal number.
    int m_digs[$];
    bit m_hold;
    int m_val;
    bit m_err;
    bit m_to;
    int m_idle;

    task automatic model_reset();
        m_digs.delete();
        m_hold = 0; m_val = 0; m_err = 0; m_to = 0; m_idle = 0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit rdy);
        m_err = 0;
        m_to  = 0;
        if (m_hold) begin
            m_idle = 0;
            if (kv && kc == 17) begin
                m_digs.delete(); m_hold = 0;
            end else begin
                if (kv) m_err = 1;
                if (rdy) begin m_digs.delete(); m_hold = 0; end
            end
        end else if (kv) begin
            m_idle = 0;
            if (kc < 10) begin
                if (m_digs.size() < 3) m_digs.push_back(kc); else m_err = 1;
            end else if (kc == 16) begin
                if (m_digs.size() > 0) void'(m_digs.pop_back());
            end else if (kc == 17) begin
                m_digs.delete();
            end else if (kc == 18) begin
                if (m_digs.size() == 0) m_err = 1;
                else begin
                    m_val = 0;
                    foreach (m_digs[i]) m_val = m_val * 10 + m_digs[i];
                    m_hold = 1;
                end
            end else begin
                m_err = 1;
            end
        end else if (m_digs.size() > 0) begin
`ifdef DEC_ENTRY_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO) begin
                m_digs.delete(); m_to = 1; m_idle = 0;
            end
`endif
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic model_check(input string tag);
        int n;
        n = m_digs.size();
        chk({tag, " cnt"},  32'(digit_cnt), n);
        chk({tag, " hund"}, 32'(d_hund), (n == 3) ? m_digs[0] : 0);
        chk({tag, " ten"},  32'(d_ten),  (n >= 2) ? m_digs[n-2] : 0);
        chk({tag, " one"},  32'(d_one),  (n >= 1) ? m_digs[n-1] : 0);
        chk({tag, " vv"},   32'(bus.val_valid), 32'(m_hold));
        chk({tag, " data"}, 32'(bus.val_data), m_val);
        chk({tag, " err"},  32'(err), 32'(m_err));
`ifdef DEC_ENTRY_TIMEOUT_EN
        chk({tag, " timeout"}, 32'(timeout), 32'(m_to));
`endif
    endtask

    task automatic do_reset();
        bus.key_valid = 1'b0;
        bus.key_code  = '0;
        bus.val_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    typedef struct {
        bit kv; int kc; bit rdy;
        int cnt; int h; int t; int o; bit vv; int data; bit err;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit kv, input int kc, input bit rdy, input int cnt,
                       input int h, input int t, input int o, input bit vv, input int data, input bit e);
        vec_t v;
        v.kv = kv; v.kc = kc; v.rdy = rdy; v.cnt = cnt;
        v.h = h; v.t = t; v.o = o; v.vv = vv; v.data = data; v.err = e;
        tbl.push_back(v);
    endtask

    task automatic hold_check(input string nm, input int cnt, input bit vv, input int data, input bit e);
        chk({nm, " cnt"},  32'(digit_cnt), cnt);
        chk({nm, " vv"},   32'(bus.val_valid), 32'(vv));
        chk({nm, " data"}, 32'(bus.val_data), data);
        chk({nm, " err"},  32'(err), 32'(e));
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = '0;
        bus.val_ready = 1'b0;

        // 1,2,3,enter then handshake
        add(1, 1, 0,  1, 0,0,1, 0,   0, 0);
        add(1, 2, 0,  2, 0,1,2, 0,   0, 0);
        add(1, 3, 0,  3, 1,2,3, 0,   0, 0);
        add(1, 18,0,  3, 1,2,3, 1, 123, 0);
        add(0, 0, 1,  0, 0,0,0, 0, 123, 0);
        // 9,9,9,4 overflow, enter
        add(1, 9, 0,  1, 0,0,9, 0, 123, 0);
        add(1, 9, 0,  2, 0,9,9, 0, 123, 0);
        add(1, 9, 0,  3, 9,9,9, 0, 123, 0);
        add(1, 4, 0,  3, 9,9,9, 0, 123, 1);
        add(1, 18,0,  3, 9,9,9, 1, 999, 0);
        add(0, 0, 1,  0, 0,0,0, 0, 999, 0);
        // 4,5,bksp,6,enter; enter on empty
        add(1, 4, 0,  1, 0,0,4, 0, 999, 0);
        add(1, 5, 0,  2, 0,4,5, 0, 999, 0);
        add(1, 16,0,  1, 0,0,4, 0, 999, 0);
        add(1, 6, 0,  2, 0,4,6, 0, 999, 0);
        add(1, 18,0,  2, 0,4,6, 1,  46, 0);
        add(0, 0, 1,  0, 0,0,0, 0,  46, 0);
        add(1, 18,0,  0, 0,0,0, 0,  46, 1);
        add(0, 0, 0,  0, 0,0,0, 0,  46, 0);
        // invalid codes, backspace to and past empty, clear
        add(1, 3, 0,  1, 0,0,3, 0,  46, 0);
        add(1, 12,0,  1, 0,0,3, 0,  46, 1);
        add(1, 31,0,  1, 0,0,3, 0,  46, 1);
        add(1, 16,0,  0, 0,0,0, 0,  46, 0);
        add(1, 16,0,  0, 0,0,0, 0,  46, 0);
        add(1, 8, 0,  1, 0,0,8, 0,  46, 0);
        add(1, 17,0,  0, 0,0,0, 0,  46, 0);

        do_reset();
        chk("reset cnt",  32'(digit_cnt), 0);
        chk("reset vv",   32'(bus.val_valid), 0);
        chk("reset data", 32'(bus.val_data), 0);
        chk("reset digs", 32'({d_hund, d_ten, d_one}), 0);
        chk("reset err",  32'(err), 0);

        foreach (tbl[i]) begin
            string s;
            s = $sformatf("vec%0d", i);
            cyc(tbl[i].kv, tbl[i].kc, tbl[i].rdy);
            chk({s, " cnt"},  32'(digit_cnt), tbl[i].cnt);
            chk({s, " hund"}, 32'(d_hund), tbl[i].h);
            chk({s, " ten"},  32'(d_ten),  tbl[i].t);
            chk({s, " one"},  32'(d_one),  tbl[i].o);
            chk({s, " vv"},   32'(bus.val_valid), 32'(tbl[i].vv));
            chk({s, " data"}, 32'(bus.val_data), tbl[i].data);
            chk({s, " err"},  32'(err), 32'(tbl[i].err));
        end

        // HOLD with consumer stalled, rejected keys, handshake with coincident key
        cyc(1, 7, 0);
        cyc(1, 18, 0);
        hold_check("hold7 enter", 1, 1, 7, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            hold_check($sformatf("hold7 stall%0d", i), 1, 1, 7, 0);
        end
        cyc(1, 3, 0);
        hold_check("hold7 digit", 1, 1, 7, 1);
        chk("hold7 one", 32'(d_one), 7);
        cyc(0, 0, 0);
        hold_check("hold7 errdrop", 1, 1, 7, 0);
        cyc(1, 18, 1);
        hold_check("hs+key", 0, 0, 7, 1);
        cyc(1, 8, 0);
        cyc(1, 18, 0);
        hold_check("hold8", 1, 1, 8, 0);
        cyc(1, 17, 0);
        hold_check("hold clear", 0, 0, 8, 0);
        chk("hold clear one", 32'(d_one), 0);

        // asynchronous reset mid-entry
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst cnt",  32'(digit_cnt), 0);
        chk("async rst digs", 32'({d_hund, d_ten, d_one}), 0);
        chk("async rst data", 32'(bus.val_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef DEC_ENTRY_TIMEOUT_EN
        do_reset();
        cyc(1, 5, 0);
        repeat (TO - 1) cyc(0, 0, 0);
        chk("to pre cnt", 32'(digit_cnt), 1);
        chk("to pre pulse", 32'(timeout), 0);
        cyc(0, 0, 0);
        chk("to fire cnt", 32'(digit_cnt), 0);
        chk("to fire pulse", 32'(timeout), 1);
        cyc(0, 0, 0);
        chk("to after pulse", 32'(timeout), 0);
        cyc(1, 5, 0);
        repeat (9) cyc(0, 0, 0);
        cyc(1, 6, 0);
        repeat (TO - 1) cyc(0, 0, 0);
        chk("to restart cnt", 32'(digit_cnt), 2);
        chk("to restart pulse", 32'(timeout), 0);
        cyc(0, 0, 0);
        chk("to restart fire", 32'(timeout), 1);
`endif

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit kv, rdy;
            int kc, r;
            kv  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            r   = $urandom_range(0, 15);
            if (r < 9)        kc = $urandom_range(0, 9);
            else if (r < 11)  kc = 16;
            else if (r == 11) kc = 17;
            else if (r < 14)  kc = 18;
            else if (r == 14) kc = $urandom_range(10, 15);
            else              kc = $urandom_range(19, 31);
            model_step(kv, kc, rdy);
            cyc(kv, kc, rdy);
            model_check($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
